// File: rtl/param_plic.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | param_plic : priority PLIC, single S-mode context, AXI4-Lite port.    |
// | Define PLIC_EDGE_MODE_EN to add per-source edge triggering. Rev 1.0  |
// +----------------------------------------------------------------------+
module param_plic #(
  parameter int NUM_SOURCES = 31,
  parameter int PRIO_BITS   = 3,
  parameter int ADDR_BITS   = 24
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic [NUM_SOURCES-1:0] irq,
  output logic                   s_interrupt,
  input  logic                   AWVALID,
  output logic                   AWREADY,
  input  logic [ADDR_BITS-1:0]   AWADDR,
  input  logic [1:0]             AWPROT,
  input  logic                   WVALID,
  output logic                   WREADY,
  input  logic [31:0]            WDATA,
  input  logic [3:0]             WSTRB,
  output logic                   BVALID,
  input  logic                   BREADY,
  output logic [1:0]             BRESP,
  input  logic                   ARVALID,
  output logic                   ARREADY,
  input  logic [ADDR_BITS-1:0]   ARADDR,
  input  logic [1:0]             ARPROT,
  output logic                   RVALID,
  input  logic                   RREADY,
  output logic [31:0]            RDATA,
  output logic [1:0]             RRESP
);
  localparam int WA = ADDR_BITS - 2;
  localparam logic [63:0]   SRC_MASK = ((64'd1 << NUM_SOURCES) - 64'd1) << 1;
  localparam logic [WA-1:0] A_PEND0 = WA'(32'h400);
  localparam logic [WA-1:0] A_PEND1 = WA'(32'h401);
  localparam logic [WA-1:0] A_EN0   = WA'(32'h800);
  localparam logic [WA-1:0] A_EN1   = WA'(32'h801);
  localparam logic [WA-1:0] A_THR   = WA'(32'h80000);
  localparam logic [WA-1:0] A_CLAIM = WA'(32'h80001);
`ifdef PLIC_EDGE_MODE_EN
  localparam logic [WA-1:0] A_EDGE0 = WA'(32'hC00);
  localparam logic [WA-1:0] A_EDGE1 = WA'(32'hC01);
`endif

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_e;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_e;

  wstate_e              wstate_q, wstate_d;
  rstate_e              rstate_q, rstate_d;
  logic [WA-1:0]        awaddr_q, ar_wa;
  logic [31:0]          rdata_q, rd_val;
  logic [PRIO_BITS-1:0] prio_q [64];
  logic [PRIO_BITS-1:0] thr_q, best_p;
  logic [63:0]          en_q, pend_q, pend_d, act_q, act_d, irq_ext, trig;
  logic [5:0]           best, cpl_id;
  logic                 s_int_q, aw_hs, w_hs, ar_hs, cpl_fire, claim_fire;
`ifdef PLIC_EDGE_MODE_EN
  logic [63:0]          edge_q, shadow_q, shadow_d, irq_prev_q, rise;
`endif
  logic                 unused_ok;

  assign unused_ok   = ^{AWPROT, ARPROT, WSTRB, AWADDR[1:0], ARADDR[1:0]};
  assign ar_wa       = ARADDR[ADDR_BITS-1:2];
  assign aw_hs       = AWVALID && AWREADY;
  assign w_hs        = WVALID && WREADY;
  assign ar_hs       = ARVALID && ARREADY;
  assign BRESP       = 2'b00;
  assign RRESP       = 2'b00;
  assign RDATA       = rdata_q;
  assign s_interrupt = s_int_q;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wstate_q <= W_IDLE;
      rstate_q <= R_IDLE;
    end else begin
      wstate_q <= wstate_d;
      rstate_q <= rstate_d;
    end
  end

  always_comb begin
    wstate_d = wstate_q;
    AWREADY  = 1'b0;
    WREADY   = 1'b0;
    BVALID   = 1'b0;
    unique case (wstate_q)
      W_IDLE: begin
        AWREADY = !ARESET;
        if (AWVALID && !ARESET) wstate_d = W_DATA;
      end
      W_DATA: begin
        WREADY = 1'b1;
        if (WVALID) wstate_d = W_RESP;
      end
      W_RESP: begin
        BVALID = 1'b1;
        if (BREADY) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    rstate_d = rstate_q;
    ARREADY  = 1'b0;
    RVALID   = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        ARREADY = !ARESET;
        if (ARVALID && !ARESET) rstate_d = R_DATA;
      end
      R_DATA: begin
        RVALID = 1'b1;
        if (RREADY) rstate_d = R_IDLE;
      end
    endcase
  end

  // Strict '>' while scanning upward keeps the lowest ID on a priority tie.
  always_comb begin
    best   = 6'd0;
    best_p = '0;
    for (int i = 1; i <= NUM_SOURCES; i++) begin
      if (pend_q[i] && (prio_q[i] > best_p)) begin
        best   = 6'(i);
        best_p = prio_q[i];
      end
    end
  end

  always_comb begin
    rd_val = 32'd0;
    if (ar_wa <= WA'(NUM_SOURCES)) begin
      rd_val = 32'(prio_q[ar_wa[5:0]]);
    end else begin
      case (ar_wa)
        A_PEND0: rd_val = pend_q[31:0];
        A_PEND1: rd_val = pend_q[63:32];
        A_EN0:   rd_val = en_q[31:0];
        A_EN1:   rd_val = en_q[63:32];
`ifdef PLIC_EDGE_MODE_EN
        A_EDGE0: rd_val = edge_q[31:0];
        A_EDGE1: rd_val = edge_q[63:32];
`endif
        A_THR:   rd_val = 32'(thr_q);
        A_CLAIM: rd_val = 32'(best);
        default: rd_val = 32'd0;
      endcase
    end
  end

  // act_q bit 0 and bits above NUM_SOURCES stay 0, so bad complete IDs fall out here.
  always_comb begin
    irq_ext    = 64'(irq) << 1;
    cpl_id     = WDATA[5:0];
    cpl_fire   = w_hs && (awaddr_q == A_CLAIM) && act_q[cpl_id];
    claim_fire = ar_hs && (ar_wa == A_CLAIM) && (best != 6'd0);
    trig       = irq_ext & en_q & ~act_q;
`ifdef PLIC_EDGE_MODE_EN
    rise       = irq_ext & ~irq_prev_q & en_q & edge_q;
    trig       = (trig & ~edge_q) | (rise & ~pend_q & ~act_q);
    shadow_d   = shadow_q | (rise & (pend_q | act_q));
`endif
    pend_d = pend_q | trig;
    act_d  = act_q;
    if (cpl_fire) begin
      act_d[cpl_id] = 1'b0;
`ifdef PLIC_EDGE_MODE_EN
      if (shadow_d[cpl_id]) begin
        pend_d[cpl_id]   = 1'b1;
        shadow_d[cpl_id] = 1'b0;
      end
`endif
    end
    if (claim_fire) begin
      pend_d[best] = 1'b0;
      act_d[best]  = 1'b1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < 64; i++) prio_q[i] <= '0;
      en_q     <= '0;
      thr_q    <= '0;
      pend_q   <= '0;
      act_q    <= '0;
      s_int_q  <= 1'b0;
      rdata_q  <= '0;
      awaddr_q <= '0;
`ifdef PLIC_EDGE_MODE_EN
      edge_q     <= '0;
      shadow_q   <= '0;
      irq_prev_q <= '0;
`endif
    end else begin
      pend_q  <= pend_d;
      act_q   <= act_d;
      s_int_q <= (best != 6'd0) && (best_p > thr_q);
`ifdef PLIC_EDGE_MODE_EN
      shadow_q   <= shadow_d;
      irq_prev_q <= irq_ext;
`endif
      if (aw_hs) awaddr_q <= AWADDR[ADDR_BITS-1:2];
      if (ar_hs) rdata_q <= rd_val;
      if (w_hs) begin
        if ((awaddr_q != '0) && (awaddr_q <= WA'(NUM_SOURCES)))
          prio_q[awaddr_q[5:0]] <= WDATA[PRIO_BITS-1:0];
        case (awaddr_q)
          A_EN0:   en_q[31:0]    <= WDATA & SRC_MASK[31:0];
          A_EN1:   en_q[63:32]   <= WDATA & SRC_MASK[63:32];
`ifdef PLIC_EDGE_MODE_EN
          A_EDGE0: edge_q[31:0]  <= WDATA & SRC_MASK[31:0];
          A_EDGE1: edge_q[63:32] <= WDATA & SRC_MASK[63:32];
`endif
          A_THR:   thr_q <= WDATA[PRIO_BITS-1:0];
          default: ;
        endcase
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_param_plic.sv
`default_nettype none
// Self-checking bench for param_plic: directed AXI4-Lite traffic against a
// cycle model of the gateway/claim rules, plus literal expectations.
module tb_param_plic;
  localparam int NS = 31;
  localparam int PB = 3;
  localparam int AB = 24;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b1;
  logic [NS-1:0] irq = '0;
  logic          s_interrupt;
  logic          AWVALID = 1'b0, AWREADY;
  logic [AB-1:0] AWADDR = '0;
  logic [1:0]    AWPROT = 2'b00;
  logic          WVALID = 1'b0, WREADY;
  logic [31:0]   WDATA = '0;
  logic [3:0]    WSTRB = 4'hF;
  logic          BVALID, BREADY = 1'b0;
  logic [1:0]    BRESP;
  logic          ARVALID = 1'b0, ARREADY;
  logic [AB-1:0] ARADDR = '0;
  logic [1:0]    ARPROT = 2'b00;
  logic          RVALID, RREADY = 1'b0;
  logic [31:0]   RDATA;
  logic [1:0]    RRESP;

  param_plic #(.NUM_SOURCES(NS), .PRIO_BITS(PB), .ADDR_BITS(AB)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .irq(irq), .s_interrupt(s_interrupt),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
  );

  always #5 ACLK = ~ACLK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL timeout %s: got no handshake expected one within 20 cycles", name);
  endtask

  // ---------------- behavioural model ----------------
  int          m_prio [64];
  logic [63:0] m_en, m_pend, m_act, m_edge, m_shadow, m_prev;
  int          m_thr;
  bit          m_sint;
  logic [31:0] m_rdata;
  bit          mw_valid = 1'b0, mr_valid = 1'b0, chk_en = 1'b0;
  int          mw_addr, mr_addr;
  logic [31:0] mw_data;

  function automatic int m_best();
    int top = 0;
    for (int i = 1; i <= NS; i++) if (m_pend[i] && m_prio[i] > top) top = m_prio[i];
    if (top == 0) return 0;
    for (int i = 1; i <= NS; i++) if (m_pend[i] && m_prio[i] == top) return i;
    return 0;
  endfunction

  function automatic logic [31:0] m_read(input int addr, input int b);
    int wa = addr >> 2;
    if (wa >= 1 && wa <= NS) return 32'(m_prio[wa]);
    case (wa)
      'h400:   return m_pend[31:0];
      'h401:   return m_pend[63:32];
      'h800:   return m_en[31:0];
      'h801:   return m_en[63:32];
`ifdef PLIC_EDGE_MODE_EN
      'hC00:   return m_edge[31:0];
      'hC01:   return m_edge[63:32];
`endif
      'h80000: return 32'(m_thr);
      'h80001: return 32'(b);
      default: return 32'd0;
    endcase
  endfunction

  function automatic void m_write(input int addr, input logic [31:0] d, input logic [63:0] old_act);
    int wa = addr >> 2;
    int id;
    if (wa >= 1 && wa <= NS) m_prio[wa] = int'(d) & ((1 << PB) - 1);
    else if (wa == 'h800) for (int i = 0; i < 32; i++) m_en[i] = d[i] && i >= 1 && i <= NS;
    else if (wa == 'h801) for (int i = 0; i < 32; i++) m_en[32+i] = d[i] && (32 + i) <= NS;
`ifdef PLIC_EDGE_MODE_EN
    else if (wa == 'hC00) for (int i = 0; i < 32; i++) m_edge[i] = d[i] && i >= 1 && i <= NS;
    else if (wa == 'hC01) for (int i = 0; i < 32; i++) m_edge[32+i] = d[i] && (32 + i) <= NS;
`endif
    else if (wa == 'h80000) m_thr = int'(d) & ((1 << PB) - 1);
    else if (wa == 'h80001) begin
      id = int'(d[5:0]);
      if (id >= 1 && id <= NS && old_act[id]) begin
        m_act[id] = 1'b0;
        if (m_shadow[id]) begin
          m_pend[id]   = 1'b1;
          m_shadow[id] = 1'b0;
        end
      end
    end
  endfunction

  always @(posedge ACLK) begin
    int b;
    bit nxt;
    logic [63:0] old_act, old_pend;
    if (ARESET) begin
      for (int i = 0; i < 64; i++) m_prio[i] = 0;
      m_en = '0; m_pend = '0; m_act = '0; m_edge = '0; m_shadow = '0; m_prev = '0;
      m_thr = 0; m_sint = 1'b0; m_rdata = '0;
    end else begin
      b   = m_best();
      nxt = (b != 0) && (m_prio[b] > m_thr);
      if (mr_valid) m_rdata = m_read(mr_addr, b);
      old_act  = m_act;
      old_pend = m_pend;
      for (int i = 1; i <= NS; i++) begin
        if (m_edge[i]) begin
          if (irq[i-1] && !m_prev[i] && m_en[i]) begin
            if (old_pend[i] || old_act[i]) m_shadow[i] = 1'b1;
            else m_pend[i] = 1'b1;
          end
        end else if (irq[i-1] && m_en[i] && !old_act[i]) begin
          m_pend[i] = 1'b1;
        end
        m_prev[i] = irq[i-1];
      end
      if (mw_valid) m_write(mw_addr, mw_data, old_act);
      if (mr_valid && (mr_addr >> 2) == 'h80001 && b != 0) begin
        m_pend[b] = 1'b0;
        m_act[b]  = 1'b1;
      end
      m_sint = nxt;
    end
  end

  always @(negedge ACLK) if (chk_en) check("s_interrupt", 32'(s_interrupt), 32'(m_sint));

  // ---------------- bus tasks ----------------
  task automatic axi_write(input int addr, input logic [31:0] data);
    int n;
    @(negedge ACLK);
    AWADDR = AB'(addr); AWVALID = 1'b1;
    n = 0;
    while (!AWREADY && n < 20) begin @(negedge ACLK); n++; end
    if (n >= 20) timeout("awready");
    @(negedge ACLK);
    AWVALID = 1'b0; WDATA = data; WVALID = 1'b1;
    n = 0;
    while (!WREADY && n < 20) begin @(negedge ACLK); n++; end
    if (n >= 20) timeout("wready");
    mw_addr = addr; mw_data = data; mw_valid = 1'b1;
    @(negedge ACLK);
    WVALID = 1'b0; mw_valid = 1'b0; BREADY = 1'b1;
    n = 0;
    while (!BVALID && n < 20) begin @(negedge ACLK); n++; end
    if (n >= 20) timeout("bvalid");
    check("bresp", 32'(BRESP), 32'd0);
    @(negedge ACLK);
    BREADY = 1'b0;
  endtask

  task automatic axi_read(input int addr, output logic [31:0] d);
    int n;
    @(negedge ACLK);
    ARADDR = AB'(addr); ARVALID = 1'b1;
    n = 0;
    while (!ARREADY && n < 20) begin @(negedge ACLK); n++; end
    if (n >= 20) timeout("arready");
    mr_addr = addr; mr_valid = 1'b1;
    @(negedge ACLK);
    ARVALID = 1'b0; mr_valid = 1'b0; RREADY = 1'b1;
    n = 0;
    while (!RVALID && n < 20) begin @(negedge ACLK); n++; end
    if (n >= 20) timeout("rvalid");
    check("rdata_model", RDATA, m_rdata);
    check("rresp", 32'(RRESP), 32'd0);
    d = RDATA;
    @(negedge ACLK);
    RREADY = 1'b0;
  endtask

  task automatic rd_expect(input string name, input int addr, input logic [31:0] exp);
    logic [31:0] d;
    axi_read(addr, d);
    check(name, d, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge ACLK);
  endtask

  localparam int A_EN0 = 'h2000, A_EN1 = 'h2004, A_PEND = 'h1000;
  localparam int A_THR = 'h200000, A_CLM = 'h200004;

  initial begin
    int n;
    repeat (3) @(negedge ACLK);
    chk_en = 1'b1;
    ARESET = 1'b0;

    // reset state
    rd_expect("reset_enable", A_EN0, 32'h0);
    rd_expect("reset_claim", A_CLM, 32'h0);
    check("reset_sint", 32'(s_interrupt), 32'd0);

    // map boundaries
    axi_write('h0, 7);
    rd_expect("prio0_ro", 'h0, 32'h0);
    axi_write('h80, 5);
    rd_expect("prio_id32_absent", 'h80, 32'h0);
    axi_write(A_EN1, 32'hFFFF_FFFF);
    rd_expect("en_word1_absent", A_EN1, 32'h0);
    axi_write(A_EN0, 32'hFFFF_FFFF);
    rd_expect("en_bit0_zero", A_EN0, 32'hFFFF_FFFE);
    axi_write(A_EN0, 0);
    axi_write(A_THR, 32'hFF);
    rd_expect("thr_width", A_THR, 32'h7);
    axi_write(A_THR, 0);
`ifndef PLIC_EDGE_MODE_EN
    axi_write('h3000, 32'hFFFF_FFFF);
    rd_expect("edge_absent", 'h3000, 32'h0);
`endif

    // equal priorities: lowest ID wins
    axi_write(12, 2);
    axi_write(20, 2);
    axi_write(A_EN0, 'h28);
    @(negedge ACLK); irq[2] = 1'b1; irq[4] = 1'b1;
    idle(3);
    check("t2_sint", 32'(s_interrupt), 32'd1);
    rd_expect("t2_claim_a", A_CLM, 32'd3);
    rd_expect("t2_claim_b", A_CLM, 32'd5);
    rd_expect("t2_claim_c", A_CLM, 32'd0);
    irq = '0;
    axi_write(A_CLM, 3);
    axi_write(A_CLM, 5);
    axi_write(A_EN0, 0);

    // one-cycle pulses, priority order
    axi_write(16, 1);
    axi_write(28, 6);
    axi_write(A_EN0, 'h90);
    @(negedge ACLK); irq[3] = 1'b1; irq[6] = 1'b1;
    @(negedge ACLK); irq = '0;
    idle(2);
    rd_expect("t3_claim_a", A_CLM, 32'd7);
    rd_expect("t3_claim_b", A_CLM, 32'd4);
    rd_expect("t3_pend", A_PEND, 32'h0);
    axi_write(A_CLM, 7);
    axi_write(A_CLM, 4);
    axi_write(A_EN0, 0);

    // threshold gating
    axi_write(8, 3);
    axi_write(A_THR, 3);
    axi_write(A_EN0, 'h4);
    @(negedge ACLK); irq[1] = 1'b1;
    idle(3);
    rd_expect("t4_pend", A_PEND, 32'h4);
    check("t4_sint_masked", 32'(s_interrupt), 32'd0);
    axi_write(A_THR, 2);
    check("t4_sint_open", 32'(s_interrupt), 32'd1);
    rd_expect("t4_claim", A_CLM, 32'd2);
    irq = '0;
    axi_write(A_CLM, 2);
    axi_write(A_THR, 0);
    axi_write(A_EN0, 0);

    // no re-pend while active; bogus complete ignored
    axi_write(24, 1);
    axi_write(A_EN0, 'h40);
    @(negedge ACLK); irq[5] = 1'b1;
    idle(2);
    rd_expect("t5_claim", A_CLM, 32'd6);
    idle(3);
    rd_expect("t5_no_repend", A_PEND, 32'h0);
    axi_write(A_CLM, 6);
    idle(1);
    rd_expect("t5_repend", A_PEND, 32'h40);
    axi_write(A_CLM, 9);
    rd_expect("t5_bogus_cpl", A_PEND, 32'h40);
    irq = '0;
    rd_expect("t5_claim2", A_CLM, 32'd6);
    axi_write(A_CLM, 6);

    // reset with a read response outstanding
    @(negedge ACLK);
    ARADDR = AB'(A_EN0); ARVALID = 1'b1;
    n = 0;
    while (!ARREADY && n < 20) begin @(negedge ACLK); n++; end
    if (n >= 20) timeout("t6_arready");
    mr_addr = A_EN0; mr_valid = 1'b1;
    @(negedge ACLK);
    ARVALID = 1'b0; mr_valid = 1'b0;
    idle(2);
    check("t6_rvalid_held", 32'(RVALID), 32'd1);
    check("t6_rdata_held", RDATA, 32'h40);
    ARESET = 1'b1;
    @(negedge ACLK);
    check("t6_rvalid_drop", 32'(RVALID), 32'd0);
    ARESET = 1'b0;
    rd_expect("t6_enable_cleared", A_EN0, 32'h0);

`ifdef PLIC_EDGE_MODE_EN
    axi_write('h3000, 'h2);
    rd_expect("edge_rb", 'h3000, 32'h2);
    axi_write(4, 1);
    axi_write(A_EN0, 'h2);
    @(negedge ACLK); irq[0] = 1'b1;
    @(negedge ACLK); irq[0] = 1'b0;
    idle(2);
    @(negedge ACLK); irq[0] = 1'b1;
    @(negedge ACLK); irq[0] = 1'b0;
    idle(2);
    rd_expect("edge_claim_a", A_CLM, 32'd1);
    axi_write(A_CLM, 1);
    idle(2);
    rd_expect("edge_claim_b", A_CLM, 32'd1);
    axi_write(A_CLM, 1);
    rd_expect("edge_claim_c", A_CLM, 32'd0);
`endif

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no end of test expected one before 300000 time units");
    $fatal(1);
  end
endmodule
`default_nettype wire
